// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial stream loader: default sizing,
// bank geometry and the loader FSM state encoding.
package poly_pkg;

  localparam int POLY_N     = 8;
  localparam int POLY_K     = 8;
  localparam int POLY_Q     = 17;
  localparam int BANK_DEPTH = POLY_N / 2;
  localparam int BANK_AW    = $clog2(BANK_DEPTH);
  localparam int NUM_BANKS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/poly_dpbram_if.sv
// Write-side view of the four banked dual-port BRAMs. Each bank has a shared
// enable/write-enable and independent a/b address and data ports.
interface DPBRAMInterface
  import poly_pkg::*;
#(
  parameter int AW = BANK_AW,
  parameter int DW = POLY_K
);
  logic [NUM_BANKS-1:0]         en;
  logic [NUM_BANKS-1:0]         we;
  logic [NUM_BANKS-1:0][AW-1:0] addr_a;
  logic [NUM_BANKS-1:0][AW-1:0] addr_b;
  logic [NUM_BANKS-1:0][DW-1:0] di_a;
  logic [NUM_BANKS-1:0][DW-1:0] di_b;

  modport loader  (output en, we, addr_a, addr_b, di_a, di_b);
  modport monitor (input  en, we, addr_a, addr_b, di_a, di_b);
endinterface

// File: rtl/poly_stream_loader_cond_sub.sv
// Single conditional subtraction into [0,Q). Inputs at or above 2Q are
// outside the contract: they are flagged and still reduced by one Q.
module mod_cond_sub #(
  parameter int K = 8,
  parameter int Q = 17
) (
  input  logic [K-1:0] x,
  output logic [K-1:0] r,
  output logic         overflow
);
  localparam logic [K-1:0] Q_K    = K'(Q);
  localparam logic [K:0]   TWO_Q  = (K+1)'(2 * Q);

  assign r        = (x >= Q_K) ? (x - Q_K) : x;
  assign overflow = ({1'b0, x} >= TWO_Q);
endmodule

// File: rtl/poly_stream_loader.sv
// Polynomial stream loader: accepts two coefficients per beat, reduces them
// into [0,Q) and writes even coefficients to bank 0, odd ones to bank 1, at
// address = beat index. One registered stage sits between accept and write.
//
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready
// are both high; s_ready depends only on loader state, never on s_valid, and
// the source must hold s_data/s_last stable while s_valid is high and the
// beat has not yet transferred.
module poly_stream_loader
  import poly_pkg::*;
#(
  parameter int N = POLY_N,
  parameter int K = POLY_K,
  parameter int Q = POLY_Q
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*K-1:0]        s_data,
  input  logic                  s_last,
  DPBRAMInterface.loader        output_brams,
  output logic                  done,
  output logic                  err,
  output loader_state_t         dbg_state
);
  localparam int AW = $clog2(N / 2);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N / 2 - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]    state;
  logic [CW-1:0] beat_cnt;
  logic          last_seen;

  logic          stage_valid;
  logic          stage_final;
  logic [AW-1:0] stage_addr;
  logic [K-1:0]  stage_even;
  logic [K-1:0]  stage_odd;

  logic [K-1:0]  r_even;
  logic [K-1:0]  r_odd;
  logic          ovf_even;
  logic          ovf_odd;
  logic          accept;
  logic          at_last_beat;
  logic          final_beat;
  logic          frame_err;

  mod_cond_sub #(.K(K), .Q(Q)) u_reduce_even (
    .x        (s_data[K-1:0]),
    .r        (r_even),
    .overflow (ovf_even)
  );

  mod_cond_sub #(.K(K), .Q(Q)) u_reduce_odd (
    .x        (s_data[2*K-1:K]),
    .r        (r_odd),
    .overflow (ovf_odd)
  );

  // Once the closing beat (early s_last or beat N/2-1) is taken, no more input.
  assign s_ready      = (state == S_LOAD) && !last_seen;
  assign accept       = s_valid && s_ready;
  assign at_last_beat = (beat_cnt == LAST_BEAT);
  assign final_beat   = s_last || at_last_beat;
  // s_last must coincide exactly with the last beat; either mismatch is a framing error.
  assign frame_err    = s_last ^ at_last_beat;
  assign done         = (state == S_DONE);
  assign dbg_state    = loader_state_t'(state);

  // FSM: leave LOAD in the cycle the closing beat's write is on the BRAM ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_LOAD;
        S_LOAD:  if (stage_valid && stage_final) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat counter, closing-beat flag and sticky error; all cleared by an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      last_seen <= 1'b0;
      err       <= 1'b0;
    end else if (state == S_IDLE && start) begin
      beat_cnt  <= '0;
      last_seen <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (final_beat) last_seen <= 1'b1;
      if (frame_err || ovf_even || ovf_odd) err <= 1'b1;
    end
  end

  // Stage register: reduced pair plus its destination address and closing flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_final <= 1'b0;
      stage_addr  <= '0;
      stage_even  <= '0;
      stage_odd   <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_final <= final_beat;
        stage_addr  <= beat_cnt[AW-1:0];
        stage_even  <= r_even;
        stage_odd   <= r_odd;
      end
    end
  end

  // BRAM drive: only port a of banks 0 and 1 is ever used; everything else stays at zero.
  always_comb begin
    output_brams.en     = '0;
    output_brams.we     = '0;
    output_brams.addr_a = '0;
    output_brams.addr_b = '0;
    output_brams.di_a   = '0;
    output_brams.di_b   = '0;
    if (stage_valid) begin
      output_brams.en[0]     = 1'b1;
      output_brams.we[0]     = 1'b1;
      output_brams.addr_a[0] = stage_addr;
      output_brams.di_a[0]   = stage_even;
      output_brams.en[1]     = 1'b1;
      output_brams.we[1]     = 1'b1;
      output_brams.addr_a[1] = stage_addr;
      output_brams.di_a[1]   = stage_odd;
    end
  end

endmodule
